// File: rtl/bootrom_pkg.sv
// Shared constants for the boot ROM: basic-computer opcodes, SPI base and the
// fixed boot image that the patch overlay sits on top of.
package bootrom_pkg;

    localparam int ROM_W = 16;

    localparam logic [ROM_W-1:0] I_BIT  = 16'h8000;
    localparam logic [ROM_W-1:0] OP_AND = 16'h0000;
    localparam logic [ROM_W-1:0] OP_ADD = 16'h1000;
    localparam logic [ROM_W-1:0] OP_LDA = 16'h2000;
    localparam logic [ROM_W-1:0] OP_STA = 16'h3000;
    localparam logic [ROM_W-1:0] OP_BUN = 16'h4000;
    localparam logic [ROM_W-1:0] OP_BSA = 16'h5000;
    localparam logic [ROM_W-1:0] OP_ISZ = 16'h6000;
    localparam logic [ROM_W-1:0] OP_CLE = 16'h7400;
    localparam logic [ROM_W-1:0] OP_CMA = 16'h7200;
    localparam logic [ROM_W-1:0] OP_CME = 16'h7100;
    localparam logic [ROM_W-1:0] OP_CIR = 16'h7080;
    localparam logic [ROM_W-1:0] OP_CIL = 16'h7040;
    localparam logic [ROM_W-1:0] OP_INC = 16'h7020;
    localparam logic [ROM_W-1:0] OP_SPA = 16'h7010;
    localparam logic [ROM_W-1:0] OP_SNA = 16'h7008;
    localparam logic [ROM_W-1:0] OP_SZA = 16'h7004;
    localparam logic [ROM_W-1:0] OP_HLT = 16'h7001;
    localparam logic [ROM_W-1:0] OP_INP = 16'hF800;
    localparam logic [ROM_W-1:0] OP_OUT = 16'hF400;
    localparam logic [ROM_W-1:0] OP_SKI = 16'hF200;

    localparam logic [7:0] SPI_BASE = 8'h90;

    // Anything past the end of the program reads as a halt.
    function automatic logic [ROM_W-1:0] rom_image(input int unsigned a);
        case (a)
            0:  return 16'hF200;
            1:  return 16'h4000;
            2:  return 16'hF800;
            3:  return 16'h1007;
            4:  return 16'hF400;
            5:  return 16'h3090;
            6:  return 16'h7010;
            7:  return 16'h0011;
            8:  return 16'h2007;
            9:  return 16'h000B;
            10: return 16'h7004;
            11: return 16'h0090;
            12: return 16'hA007;
            13: return 16'h9011;
            14: return 16'hB00B;
            15: return 16'h7200;
            16: return 16'h7008;
            17: return 16'h0007;
            18: return 16'h7080;
            19: return 16'hF400;
            20: return 16'h7400;
            21: return 16'h7040;
            22: return 16'hF400;
            23: return 16'h7020;
            24: return 16'h7100;
            25: return 16'h7040;
            26: return 16'hF400;
            27: return 16'h501E;
            28: return 16'h6091;
            29: return 16'h7001;
            30: return 16'h001C;
            31: return 16'hC01E;
            default: return OP_HLT;
        endcase
    endfunction

endpackage

// File: rtl/bootrom_patch_if.sv
// CPU-side bus of the boot ROM: access request, patch write data, lock pulse
// and the registered read/status outputs.
interface bootrom_patch_if #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 5,
    parameter int PATCH_N = 4
);
    localparam int CNT_W = $clog2(PATCH_N + 1);

    logic              cs;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic              lock;
    logic [DATA_W-1:0] dout;
    logic              rd_valid;
    logic              locked;
    logic [CNT_W-1:0]  patch_cnt;
    logic              err;

    modport master (
        output cs, we, addr, din, lock,
        input  dout, rd_valid, locked, patch_cnt, err
    );

    modport slave (
        input  cs, we, addr, din, lock,
        output dout, rd_valid, locked, patch_cnt, err
    );
endinterface

// File: rtl/bootrom_patch_cam.sv
// Fully-associative patch table: per-entry valid/address/data with a
// combinational lookup. Which entry to write is decided by the caller.
module patch_cam #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 5,
    parameter int PATCH_N = 4,
    parameter int IDX_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [IDX_W-1:0]  hit_idx,
    output logic [DATA_W-1:0] hit_data
);
    logic [PATCH_N-1:0] valid;
    logic [ADDR_W-1:0]  tag  [PATCH_N];
    logic [DATA_W-1:0]  data [PATCH_N];

    always_ff @(posedge clk) begin
        if (!rst_n)
            valid <= '0;
        else if (wr_en)
            valid[wr_idx] <= 1'b1;
    end

    // Tag/data need no reset: an entry is ignored until its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag[wr_idx]  <= wr_addr;
            data[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_data = '0;
        for (int i = 0; i < PATCH_N; i++) begin
            if (valid[i] && tag[i] == lookup_addr) begin
                hit      = 1'b1;
                hit_idx  = IDX_W'(i);
                hit_data = data[i];
            end
        end
    end
endmodule

// File: rtl/bootrom_patch.sv
// Boot ROM with a write-once patch overlay: registered reads, patch
// allocation in fill order, lock and sticky error for dropped writes.
module bootrom_patch
    import bootrom_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 5,
    parameter int PATCH_N = 4
) (
    input logic            clk,
    input logic            rst_n,
    bootrom_patch_if.slave bus
);
    localparam int CNT_W = $clog2(PATCH_N + 1);
    localparam int IDX_W = (PATCH_N > 1) ? $clog2(PATCH_N) : 1;

    logic              rd_req;
    logic              wr_req;
    logic              has_room;
    logic              cam_we;
    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] hit_data;
    logic [CNT_W-1:0]  cnt;

    assign rd_req   = bus.cs & ~bus.we;
    assign wr_req   = bus.cs & bus.we;
    assign has_room = cnt < CNT_W'(PATCH_N);

    // A hit rewrites its own entry, so an address never occupies two slots.
    assign cam_we = wr_req & ~bus.locked & (hit | has_room);
    assign wr_idx = hit ? hit_idx : cnt[IDX_W-1:0];

    patch_cam #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .PATCH_N(PATCH_N),
        .IDX_W  (IDX_W)
    ) u_cam (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (cam_we),
        .wr_idx     (wr_idx),
        .wr_addr    (bus.addr),
        .wr_data    (bus.din),
        .lookup_addr(bus.addr),
        .hit        (hit),
        .hit_idx    (hit_idx),
        .hit_data   (hit_data)
    );

    assign bus.patch_cnt = cnt;

    // The lock samples the pre-edge locked value, so a same-cycle write lands first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.dout     <= '0;
            bus.rd_valid <= 1'b0;
            bus.locked   <= 1'b0;
            bus.err      <= 1'b0;
            cnt          <= '0;
        end else begin
            bus.rd_valid <= rd_req;
            if (rd_req)
                bus.dout <= hit ? hit_data : DATA_W'(rom_image(32'(bus.addr)));
            if (wr_req && (bus.locked || (!hit && !has_room)))
                bus.err <= 1'b1;
            if (cam_we && !hit)
                cnt <= cnt + 1'b1;
            if (bus.lock)
                bus.locked <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bootrom_patch.sv
// Randomised scoreboard bench for bootrom_patch against a map-based model of
// the boot image plus patch table.
module tb_bootrom_patch;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    bootrom_patch_if #(.DATA_W(16), .ADDR_W(5), .PATCH_N(4)) bus ();

    bootrom_patch #(.DATA_W(16), .ADDR_W(5), .PATCH_N(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [15:0] rom_ref [32] = '{
        16'hF200, 16'h4000, 16'hF800, 16'h1007, 16'hF400, 16'h3090, 16'h7010, 16'h0011,
        16'h2007, 16'h000B, 16'h7004, 16'h0090, 16'hA007, 16'h9011, 16'hB00B, 16'h7200,
        16'h7008, 16'h0007, 16'h7080, 16'hF400, 16'h7400, 16'h7040, 16'hF400, 16'h7020,
        16'h7100, 16'h7040, 16'hF400, 16'h501E, 16'h6091, 16'h7001, 16'h001C, 16'hC01E
    };

    logic [15:0] patch_map [int];
    int          m_cnt;
    bit          m_err;
    bit          m_locked;
    logic [15:0] hold_dout;
    logic [15:0] exp_q [$];
    bit          mon_en = 1'b0;
    int          checks = 0;
    int          failures = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle from a negedge, then advance the model at the posedge it takes effect.
    task automatic apply_stimulus(input bit rn, input bit c, input bit w, input bit l,
                                  input logic [4:0] a, input logic [15:0] d);
        rst_n    = rn;
        bus.cs   = c;
        bus.we   = w;
        bus.lock = l;
        bus.addr = a;
        bus.din  = d;
        if (rn && c && !w)
            exp_q.push_back(patch_map.exists(int'(a)) ? patch_map[int'(a)] : rom_ref[a]);
        @(posedge clk);
        if (!rn) begin
            patch_map.delete();
            m_cnt     = 0;
            m_err     = 1'b0;
            m_locked  = 1'b0;
            hold_dout = 16'h0000;
            exp_q.delete();
        end else begin
            if (c && w) begin
                if (m_locked)
                    m_err = 1'b1;
                else if (patch_map.exists(int'(a)))
                    patch_map[int'(a)] = d;
                else if (m_cnt < 4) begin
                    patch_map[int'(a)] = d;
                    m_cnt++;
                end else
                    m_err = 1'b1;
            end
            if (l)
                m_locked = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic rd(input logic [4:0] a);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, a, 16'h0000);
    endtask

    task automatic wr(input logic [4:0] a, input logic [15:0] d);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, a, d);
    endtask

    task automatic idle();
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0000);
    endtask

    initial begin
        logic [15:0] e;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (bus.rd_valid) begin
                if (exp_q.size() == 0)
                    check_output("rd_valid", 32'(bus.rd_valid), 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check_output("read_dout", 32'(bus.dout), 32'(e));
                    hold_dout = e;
                end
            end else
                check_output("hold_dout", 32'(bus.dout), 32'(hold_dout));
            check_output("patch_cnt", 32'(bus.patch_cnt), 32'(m_cnt));
            check_output("err", 32'(bus.err), 32'(m_err));
            check_output("locked", 32'(bus.locked), 32'(m_locked));
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int r;
        logic [4:0] a;
        rst_n = 1'b0;
        bus.cs = 1'b0; bus.we = 1'b0; bus.lock = 1'b0; bus.addr = '0; bus.din = '0;
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0000);
        mon_en = 1'b1;

        $display("[TB] reset and plain ROM reads");
        rd(5'h00); rd(5'h1F); idle();

        $display("[TB] patch insert, overwrite, read-after-write");
        wr(5'h03, 16'h1234); rd(5'h03); rd(5'h04);
        wr(5'h03, 16'h5678); rd(5'h03);

        $display("[TB] table full and overflow");
        wr(5'h06, 16'h0606); wr(5'h07, 16'h0707); wr(5'h08, 16'h0808);
        wr(5'h09, 16'h0909); rd(5'h09);
        wr(5'h06, 16'hBEEF); rd(5'h06);

        $display("[TB] lock");
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 16'h0000);
        wr(5'h05, 16'hAAAA); rd(5'h05); wr(5'h03, 16'h1111); rd(5'h03);

        $display("[TB] reset during read");
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0000);
        wr(5'h00, 16'hCAFE); rd(5'h00);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'h00, 16'h0000);
        rd(5'h00);
        wr(5'h02, 16'h2222);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 5'h04, 16'h4444);
        rd(5'h04); rd(5'h02);

        $display("[TB] random traffic");
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0000);
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            a = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            if (r < 2)
                apply_stimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, a, 16'h0000);
            else if (r < 4)
                apply_stimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, a, 16'($urandom));
            else if (r < 50)
                rd(a);
            else if (r < 85)
                wr(a, 16'($urandom));
            else
                idle();
        end

        idle(); idle();
        check_output("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
